tlu_multi_trigger_ctrl: RTL and testbench

Parametrised trigger controller that takes the place of the single-input TLU controller in the MultiIO readout path. It combines up to CHANNELS trigger inputs through a per-channel enable/invert mask and OR/AND coincidence logic, and runs the EUDET TLU handshake (none, simple, or trigger-data). It numbers each accepted trigger and pushes 32-bit trigger words into an internal first-word-fall-through FIFO for the readout arbiter. Configuration arrives as static ports driven by the register block.

---
 rtl/tlu_multi_trigger_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_tlu_multi_trigger_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlu_multi_trigger_ctrl.sv
// Trigger controller: masked OR/AND coincidence over CHANNELS inputs, EUDET TLU handshake, numbered words into a FWFT FIFO.
// Latency: edge in cycle N -> word written end of N+2 (mode 11 adds WAIT_LOW + TRIGGER_BITS*DIVISOR); TRIGGER_FLAG in N+3.
// Backpressure: full FIFO or FIFO_NEAR_FULL drops the trigger into LOST_COUNT; TLU_BUSY held until CMD_READY and !FIFO_NEAR_FULL.
// Optional build macro TLU_TIMESTAMP_EN: adds a free-running timestamp and a second word per trigger.

// Generic first-word-fall-through FIFO; head word visible on rd_dat while rd_vld.
// Latency: a word pushed in cycle N is visible in cycle N+1.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
module tlu_trig_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     BUS_CLK,
    input  logic                     RST,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_rdy,
    output logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign rd_vld = (count != '0);
    assign pop    = rd_rdy && rd_vld;
    assign push   = wr_vld && ((count != (AW+1)'(DEPTH)) || pop);
    // Empty FIFO presents zero rather than stale memory contents.
    assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {AW'(0), push} - {AW'(0), pop};
        end
    end

    // Storage array; no reset needed since the pointers define validity.
    always_ff @(posedge BUS_CLK) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end
endmodule

// Trigger controller top: coincidence, handshake FSM, trigger numbering, loss accounting.
// Latency: see file header; TLU_BUSY rises in N+2 for handshake modes.
// Backpressure: drops counted in LOST_COUNT (saturating); edges arriving outside IDLE are also counted as lost.
module tlu_multi_trigger_ctrl #(
    parameter int DIVISOR      = 12,
    parameter int CHANNELS     = 4,
    parameter int TRIGGER_BITS = 15,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                BUS_CLK,
    input  logic                BUS_RST,
    input  logic [CHANNELS-1:0] TRIGGER_IN,
    input  logic [CHANNELS-1:0] ENABLE_MASK,
    input  logic [CHANNELS-1:0] INVERT_MASK,
    input  logic                COINCIDENCE_AND,
    input  logic [1:0]          TLU_MODE,
    input  logic                DATA_MSB_FIRST,
    input  logic [7:0]          LOW_TIMEOUT,
    input  logic                COUNTER_RESET,
    input  logic                CMD_READY,
    input  logic                FIFO_NEAR_FULL,
    output logic                TLU_BUSY,
    output logic                TLU_CLOCK,
    output logic                TRIGGER_FLAG,
    input  logic                FIFO_READ,
    output logic                FIFO_EMPTY,
    output logic [31:0]         FIFO_DATA,
    output logic [7:0]          LOST_COUNT,
    output logic                TIMEOUT_ERROR
);
    localparam int HALF = DIVISOR / 2;
    localparam int DW   = $clog2(DIVISOR);
    localparam int BW   = $clog2(TRIGGER_BITS + 1);
    localparam int FAW  = $clog2(FIFO_DEPTH);
`ifdef TLU_TIMESTAMP_EN
    localparam int WORDS = 2;
`else
    localparam int WORDS = 1;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        WAIT_LOW,
        SHIFT,
        WRITE,
`ifdef TLU_TIMESTAMP_EN
        WRITE_TS,
`endif
        WAIT_READY
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CHANNELS-1:0]     polar;
    logic                    comb;
    logic                    comb_d;
    logic                    rise;
    logic [1:0]              mode_q;
    logic [7:0]              wait_cnt;
    logic [DW-1:0]           div_cnt;
    logic [BW-1:0]           bit_cnt;
    logic [TRIGGER_BITS-1:0] shift_q;
    logic [TRIGGER_BITS-1:0] din_vec;
    logic [30:0]             trig_cnt;
    logic [30:0]             trig_num;
    logic                    busy_q;
    logic                    flag_q;
    logic                    timeout_q;
    logic [7:0]              lost_q;
    logic [1:0]              lost_inc;
    logic [8:0]              lost_sum;
    logic [FAW:0]            fifo_count;
    logic                    fifo_vld;
    logic                    has_room;
    logic                    push_vld;
    logic [31:0]             push_dat;
    logic                    write_evt;
    logic                    drop;
    logic                    busy_set;
    logic                    busy_clr;
    logic                    timeout_set;
`ifdef TLU_TIMESTAMP_EN
    logic [31:0]             ts_cnt;
    logic [31:0]             ts_q;
`endif

    // Disabled channels are forced neutral for the chosen reduction; no enabled channel gives 0.
    assign polar = TRIGGER_IN ^ INVERT_MASK;
    assign comb  = COINCIDENCE_AND ? ((ENABLE_MASK != '0) && (&(polar | ~ENABLE_MASK)))
                                   : (|(polar & ENABLE_MASK));
    assign rise  = comb && !comb_d;

    assign has_room = (fifo_count <= (FAW+1)'(FIFO_DEPTH - WORDS));
    assign trig_num = (mode_q == 2'b11) ? 31'(shift_q) : trig_cnt;
    assign din_vec  = TRIGGER_IN[0] ? TRIGGER_BITS'(1) : '0;

    assign lost_inc = {1'b0, rise && (state != IDLE)} + {1'b0, drop};
    assign lost_sum = {1'b0, lost_q} + {7'b0, lost_inc};

    assign TLU_BUSY      = busy_q;
    assign TLU_CLOCK     = (state == SHIFT) && (div_cnt < DW'(HALF));
    assign TRIGGER_FLAG  = flag_q;
    assign LOST_COUNT    = lost_q;
    assign TIMEOUT_ERROR = timeout_q;
    assign FIFO_EMPTY    = !fifo_vld;

    // State register.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state and per-state control strobes.
    always_comb begin
        state_nxt   = state;
        push_vld    = 1'b0;
        push_dat    = {1'b1, trig_num};
        write_evt   = 1'b0;
        drop        = 1'b0;
        busy_set    = 1'b0;
        busy_clr    = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (rise && (TLU_MODE != 2'b00)) state_nxt = ACCEPT;
            end
            ACCEPT: begin
                if (!has_room || FIFO_NEAR_FULL) begin
                    drop      = 1'b1;
                    state_nxt = IDLE;
                end else if (mode_q == 2'b01) begin
                    state_nxt = WRITE;
                end else begin
                    busy_set  = 1'b1;
                    state_nxt = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!comb) begin
                    state_nxt = (mode_q == 2'b11) ? SHIFT : WRITE;
                end else if ((LOW_TIMEOUT != 8'd0) && (wait_cnt == LOW_TIMEOUT - 8'd1)) begin
                    timeout_set = 1'b1;
                    state_nxt   = WAIT_READY;
                end
            end
            SHIFT: begin
                if ((div_cnt == DW'(DIVISOR - 1)) && (bit_cnt == BW'(TRIGGER_BITS - 1)))
                    state_nxt = WRITE;
            end
            WRITE: begin
                push_vld  = 1'b1;
                write_evt = 1'b1;
`ifdef TLU_TIMESTAMP_EN
                state_nxt = WRITE_TS;
`else
                state_nxt = (mode_q == 2'b01) ? IDLE : WAIT_READY;
`endif
            end
`ifdef TLU_TIMESTAMP_EN
            WRITE_TS: begin
                push_vld  = 1'b1;
                push_dat  = {1'b0, ts_q[30:0]};
                state_nxt = (mode_q == 2'b01) ? IDLE : WAIT_READY;
            end
`endif
            WAIT_READY: begin
                if (CMD_READY && !FIFO_NEAR_FULL) begin
                    busy_clr  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Edge history and mode capture; the mode only follows TLU_MODE while idle so a handshake finishes as started.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            comb_d <= 1'b0;
            mode_q <= 2'b00;
        end else begin
            comb_d <= comb;
            if (state == IDLE) mode_q <= TLU_MODE;
        end
    end

    // Low-wait timer and TLU clock divider / bit counter, both idle at zero outside their states.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            wait_cnt <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
        end else begin
            wait_cnt <= (state == WAIT_LOW) ? wait_cnt + 8'd1 : 8'd0;
            if (state != SHIFT) begin
                div_cnt <= '0;
                bit_cnt <= '0;
            end else if (div_cnt == DW'(DIVISOR - 1)) begin
                div_cnt <= '0;
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // TLU data capture on the last high cycle of each TLU_CLOCK period, i.e. at its falling edge.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            shift_q <= '0;
        end else if ((state == SHIFT) && (div_cnt == DW'(HALF - 1))) begin
            if (DATA_MSB_FIRST) shift_q <= (shift_q << 1) | din_vec;
            else                shift_q <= (shift_q >> 1) | (din_vec << (TRIGGER_BITS - 1));
        end
    end

    // Trigger counter; a clear wins over a coincident increment.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST || COUNTER_RESET) trig_cnt <= '0;
        else if (write_evt)           trig_cnt <= trig_cnt + 31'd1;
    end

    // Status outputs: busy, flag pulse, sticky timeout, saturating loss counter.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            busy_q    <= 1'b0;
            flag_q    <= 1'b0;
            timeout_q <= 1'b0;
            lost_q    <= '0;
        end else begin
            if (busy_set)      busy_q <= 1'b1;
            else if (busy_clr) busy_q <= 1'b0;
            flag_q    <= write_evt;
            timeout_q <= timeout_q | timeout_set;
            lost_q    <= lost_sum[8] ? 8'hFF : lost_sum[7:0];
        end
    end

`ifdef TLU_TIMESTAMP_EN
    // Free-running timestamp, captured when a trigger is being accepted.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            ts_cnt <= '0;
            ts_q   <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (state == ACCEPT) ts_q <= ts_cnt;
        end
    end
`endif

    tlu_trig_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .BUS_CLK (BUS_CLK),
        .RST     (BUS_RST),
        .wr_vld  (push_vld),
        .wr_dat  (push_dat),
        .rd_rdy  (FIFO_READ),
        .rd_vld  (fifo_vld),
        .rd_dat  (FIFO_DATA),
        .count   (fifo_count)
    );
endmodule

// File: tb/tb_tlu_multi_trigger_ctrl.sv
// Directed bench for tlu_multi_trigger_ctrl with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
// Each scenario task resets the design and checks its own results.
module tb_tlu_multi_trigger_ctrl;
    localparam int DIVISOR      = 12;
    localparam int CHANNELS     = 4;
    localparam int TRIGGER_BITS = 15;
    localparam int FIFO_DEPTH   = 8;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST;
    logic [3:0]  TRIGGER_IN;
    logic [3:0]  ENABLE_MASK;
    logic [3:0]  INVERT_MASK;
    logic        COINCIDENCE_AND;
    logic [1:0]  TLU_MODE;
    logic        DATA_MSB_FIRST;
    logic [7:0]  LOW_TIMEOUT;
    logic        COUNTER_RESET;
    logic        CMD_READY;
    logic        FIFO_NEAR_FULL;
    logic        TLU_BUSY;
    logic        TLU_CLOCK;
    logic        TRIGGER_FLAG;
    logic        FIFO_READ;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic [7:0]  LOST_COUNT;
    logic        TIMEOUT_ERROR;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int flag_cnt = 0;

    tlu_multi_trigger_ctrl #(
        .DIVISOR(DIVISOR), .CHANNELS(CHANNELS), .TRIGGER_BITS(TRIGGER_BITS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .TRIGGER_IN(TRIGGER_IN), .ENABLE_MASK(ENABLE_MASK),
        .INVERT_MASK(INVERT_MASK), .COINCIDENCE_AND(COINCIDENCE_AND), .TLU_MODE(TLU_MODE),
        .DATA_MSB_FIRST(DATA_MSB_FIRST), .LOW_TIMEOUT(LOW_TIMEOUT), .COUNTER_RESET(COUNTER_RESET),
        .CMD_READY(CMD_READY), .FIFO_NEAR_FULL(FIFO_NEAR_FULL), .TLU_BUSY(TLU_BUSY),
        .TLU_CLOCK(TLU_CLOCK), .TRIGGER_FLAG(TRIGGER_FLAG), .FIFO_READ(FIFO_READ),
        .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA), .LOST_COUNT(LOST_COUNT),
        .TIMEOUT_ERROR(TIMEOUT_ERROR)
    );

    always #5 BUS_CLK = ~BUS_CLK;
    always @(posedge BUS_CLK) cyc++;
    always @(negedge BUS_CLK) if (TRIGGER_FLAG === 1'b1) flag_cnt++;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge BUS_CLK);
    endtask

    task automatic setup(input logic [1:0] mode, input logic [3:0] en, input logic [3:0] inv,
                         input logic and_mode, input logic [7:0] tmo, input logic ready);
        TLU_MODE = mode; ENABLE_MASK = en; INVERT_MASK = inv; COINCIDENCE_AND = and_mode;
        LOW_TIMEOUT = tmo; CMD_READY = ready; TRIGGER_IN = '0; DATA_MSB_FIRST = 1'b0;
        COUNTER_RESET = 1'b0; FIFO_NEAR_FULL = 1'b0; FIFO_READ = 1'b0;
        BUS_RST = 1'b1;
        tick(2);
        BUS_RST = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] v);
        TRIGGER_IN = v;
        tick(1);
        TRIGGER_IN = '0;
    endtask

    task automatic test_reset;
        setup(2'b01, 4'b0001, 4'b0000, 1'b0, 8'd0, 1'b1);
        total++;
        if ({TLU_BUSY, TLU_CLOCK, TRIGGER_FLAG, FIFO_EMPTY, TIMEOUT_ERROR} !== 5'b00010) begin
            bad++; $display("FAIL reset_flags: got %b want 00010", {TLU_BUSY, TLU_CLOCK, TRIGGER_FLAG, FIFO_EMPTY, TIMEOUT_ERROR});
        end
        total++;
        if (FIFO_DATA !== 32'h0 || LOST_COUNT !== 8'd0) begin
            bad++; $display("FAIL reset_data: got data=%h lost=%0d want 0/0", FIFO_DATA, LOST_COUNT);
        end
    endtask

    task automatic test_mode01_or;
        int f0;
        setup(2'b01, 4'b0011, 4'b0000, 1'b0, 8'd0, 1'b1);
        f0 = flag_cnt;
        pulse(4'b0010);                                  // edge in cycle N, now at N+1
        total++;
        if (TRIGGER_FLAG !== 1'b0) begin bad++; $display("FAIL or_flag_n1: got %b want 0", TRIGGER_FLAG); end
        tick(1);                                         // N+2
        total++;
        if (FIFO_EMPTY !== 1'b1 || TRIGGER_FLAG !== 1'b0) begin
            bad++; $display("FAIL or_n2: got empty=%b flag=%b want 1/0", FIFO_EMPTY, TRIGGER_FLAG);
        end
        tick(1);                                         // N+3
        total++;
        if (FIFO_EMPTY !== 1'b0 || TRIGGER_FLAG !== 1'b1 || FIFO_DATA !== 32'h8000_0000) begin
            bad++; $display("FAIL or_n3: got empty=%b flag=%b data=%h want 0/1/80000000", FIFO_EMPTY, TRIGGER_FLAG, FIFO_DATA);
        end
        tick(1);
        total++;
        if (TRIGGER_FLAG !== 1'b0) begin bad++; $display("FAIL or_flag_n4: got %b want 0", TRIGGER_FLAG); end
        pulse(4'b0010); tick(4);
        pulse(4'b0010); tick(4);
        total++;
        if (flag_cnt - f0 !== 3) begin bad++; $display("FAIL or_flag_count: got %0d want 3", flag_cnt - f0); end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (FIFO_EMPTY !== 1'b0 || FIFO_DATA !== 32'h8000_0000 + k) begin
                bad++; $display("FAIL or_word%0d: got empty=%b data=%h want %h", k, FIFO_EMPTY, FIFO_DATA, 32'h8000_0000 + k);
            end
            FIFO_READ = 1'b1; tick(1); FIFO_READ = 1'b0;
        end
        total++;
        if (FIFO_EMPTY !== 1'b1 || FIFO_DATA !== 32'h0) begin
            bad++; $display("FAIL or_drained: got empty=%b data=%h want 1/0", FIFO_EMPTY, FIFO_DATA);
        end
    endtask

    task automatic test_and_invert;
        int f0;
        setup(2'b01, 4'b0011, 4'b0010, 1'b1, 8'd0, 1'b1);
        f0 = flag_cnt;
        TRIGGER_IN = 4'b0001; tick(4);
        total++;
        if (flag_cnt - f0 !== 1 || FIFO_DATA !== 32'h8000_0000) begin
            bad++; $display("FAIL and_hit: got flags=%0d data=%h want 1/80000000", flag_cnt - f0, FIFO_DATA);
        end
        TRIGGER_IN = 4'b0000; tick(2);
        TRIGGER_IN = 4'b0011; tick(5);
        total++;
        if (flag_cnt - f0 !== 1) begin bad++; $display("FAIL and_blocked: got flags=%0d want 1", flag_cnt - f0); end
        FIFO_READ = 1'b1; tick(1); FIFO_READ = 1'b0;
        TRIGGER_IN = 4'b0000; COINCIDENCE_AND = 1'b0; ENABLE_MASK = 4'b0000; INVERT_MASK = 4'b0000; tick(1);
        TRIGGER_IN = 4'b1111; tick(5);
        total++;
        if (FIFO_EMPTY !== 1'b1 || flag_cnt - f0 !== 1) begin
            bad++; $display("FAIL none_enabled: got empty=%b flags=%0d want 1/1", FIFO_EMPTY, flag_cnt - f0);
        end
        TRIGGER_IN = 4'b0000;
    endtask

    task automatic test_disabled;
        setup(2'b00, 4'b0001, 4'b0000, 1'b0, 8'd0, 1'b1);
        pulse(4'b0001); tick(5);
        total++;
        if (FIFO_EMPTY !== 1'b1 || LOST_COUNT !== 8'd0 || TLU_BUSY !== 1'b0) begin
            bad++; $display("FAIL mode00: got empty=%b lost=%0d busy=%b want 1/0/0", FIFO_EMPTY, LOST_COUNT, TLU_BUSY);
        end
    endtask

    task automatic test_mode11_shift;
        logic [14:0] tlu_data;
        int t0;
        int highs;
        int guard;
        tlu_data = 15'h1234;
        highs = 0;
        setup(2'b11, 4'b0001, 4'b0000, 1'b0, 8'd0, 1'b0);
        TRIGGER_IN = 4'b0001; tick(1);                   // N+1
        total++;
        if (TLU_BUSY !== 1'b0) begin bad++; $display("FAIL m11_busy_n1: got %b want 0", TLU_BUSY); end
        tick(1);                                         // N+2
        total++;
        if (TLU_BUSY !== 1'b1) begin bad++; $display("FAIL m11_busy_n2: got %b want 1", TLU_BUSY); end
        TRIGGER_IN = 4'b0000;
        guard = 0;
        tick(1);
        while (TLU_CLOCK !== 1'b1 && guard < 50) begin tick(1); guard++; end
        total++;
        if (TLU_CLOCK !== 1'b1) begin
            bad++; $display("FAIL m11_clock_start: got %b want 1 within 50 cycles", TLU_CLOCK);
        end else begin
            t0 = cyc;
            for (int i = 0; i < TRIGGER_BITS; i++) begin
                TRIGGER_IN[0] = tlu_data[i];
                repeat (DIVISOR) begin
                    if (TLU_CLOCK === 1'b1) highs++;
                    tick(1);
                end
            end
            TRIGGER_IN = 4'b0000;
            guard = 0;
            while (FIFO_EMPTY !== 1'b0 && guard < 20) begin tick(1); guard++; end
            total++;
            if (cyc - t0 !== 181) begin bad++; $display("FAIL m11_shift_len: got %0d want 181", cyc - t0); end
            total++;
            if (highs !== 90) begin bad++; $display("FAIL m11_clock_high: got %0d want 90", highs); end
            total++;
            if (FIFO_DATA !== 32'h8000_1234) begin bad++; $display("FAIL m11_word: got %h want 80001234", FIFO_DATA); end
        end
        tick(5);
        total++;
        if (TLU_BUSY !== 1'b1 || TLU_CLOCK !== 1'b0) begin
            bad++; $display("FAIL m11_hold: got busy=%b clk=%b want 1/0", TLU_BUSY, TLU_CLOCK);
        end
        CMD_READY = 1'b1; tick(1);
        total++;
        if (TLU_BUSY !== 1'b0) begin bad++; $display("FAIL m11_release: got %b want 0", TLU_BUSY); end
    endtask

    task automatic test_timeout;
        int f0;
        setup(2'b10, 4'b0001, 4'b0000, 1'b0, 8'd20, 1'b1);
        f0 = flag_cnt;
        TRIGGER_IN = 4'b0001; tick(21);                  // N+21
        total++;
        if (TIMEOUT_ERROR !== 1'b0 || TLU_BUSY !== 1'b1) begin
            bad++; $display("FAIL tmo_before: got err=%b busy=%b want 0/1", TIMEOUT_ERROR, TLU_BUSY);
        end
        tick(1);                                         // N+22
        total++;
        if (TIMEOUT_ERROR !== 1'b1 || TLU_BUSY !== 1'b1) begin
            bad++; $display("FAIL tmo_set: got err=%b busy=%b want 1/1", TIMEOUT_ERROR, TLU_BUSY);
        end
        tick(1);
        total++;
        if (TLU_BUSY !== 1'b0 || FIFO_EMPTY !== 1'b1 || flag_cnt - f0 !== 0) begin
            bad++; $display("FAIL tmo_after: got busy=%b empty=%b flags=%0d want 0/1/0", TLU_BUSY, FIFO_EMPTY, flag_cnt - f0);
        end
        TRIGGER_IN = 4'b0000; tick(3);
        total++;
        if (TIMEOUT_ERROR !== 1'b1) begin bad++; $display("FAIL tmo_sticky: got %b want 1", TIMEOUT_ERROR); end
    endtask

    task automatic test_overflow;
        setup(2'b01, 4'b0001, 4'b0000, 1'b0, 8'd0, 1'b1);
        for (int k = 0; k < FIFO_DEPTH; k++) begin pulse(4'b0001); tick(3); end
        total++;
        if (LOST_COUNT !== 8'd0 || FIFO_EMPTY !== 1'b0) begin
            bad++; $display("FAIL ovf_fill: got lost=%0d empty=%b want 0/0", LOST_COUNT, FIFO_EMPTY);
        end
        for (int k = 0; k < 10; k++) begin pulse(4'b0001); tick(3); end
        total++;
        if (LOST_COUNT !== 8'd10) begin bad++; $display("FAIL ovf_lost10: got %0d want 10", LOST_COUNT); end
        for (int k = 0; k < 290; k++) begin pulse(4'b0001); tick(3); end
        total++;
        if (LOST_COUNT !== 8'd255) begin bad++; $display("FAIL ovf_saturate: got %0d want 255", LOST_COUNT); end
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            total++;
            if (FIFO_EMPTY !== 1'b0 || FIFO_DATA !== 32'h8000_0000 + k) begin
                bad++; $display("FAIL ovf_word%0d: got empty=%b data=%h want %h", k, FIFO_EMPTY, FIFO_DATA, 32'h8000_0000 + k);
            end
            FIFO_READ = 1'b1; tick(1); FIFO_READ = 1'b0;
        end
        FIFO_NEAR_FULL = 1'b1;
        pulse(4'b0001); tick(4);
        total++;
        if (FIFO_EMPTY !== 1'b1) begin bad++; $display("FAIL near_full_drop: got empty=%b want 1", FIFO_EMPTY); end
        FIFO_NEAR_FULL = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_words [6];
        exp_words[0] = 32'h8000_0000; exp_words[1] = 32'h8000_0001; exp_words[2] = 32'h8000_0002;
        exp_words[3] = 32'h8000_0003; exp_words[4] = 32'h8000_0004; exp_words[5] = 32'h8000_0000;
        setup(2'b01, 4'b0001, 4'b0000, 1'b0, 8'd0, 1'b1);
        pulse(4'b0001); tick(2);
        pulse(4'b0001); tick(2);
        pulse(4'b0001); tick(5);
        total++;
        if (LOST_COUNT !== 8'd0) begin bad++; $display("FAIL b2b_spacing3: got lost=%0d want 0", LOST_COUNT); end
        pulse(4'b0001); tick(1);
        pulse(4'b0001); tick(5);
        total++;
        if (LOST_COUNT !== 8'd1) begin bad++; $display("FAIL b2b_spacing2: got lost=%0d want 1", LOST_COUNT); end
        pulse(4'b0001); tick(1);                         // WRITE cycle of word 4
        COUNTER_RESET = 1'b1; tick(1); COUNTER_RESET = 1'b0;
        tick(3);
        pulse(4'b0001); tick(4);
        for (int k = 0; k < 6; k++) begin
            total++;
            if (FIFO_EMPTY !== 1'b0 || FIFO_DATA !== exp_words[k]) begin
                bad++; $display("FAIL b2b_word%0d: got empty=%b data=%h want %h", k, FIFO_EMPTY, FIFO_DATA, exp_words[k]);
            end
            FIFO_READ = 1'b1; tick(1); FIFO_READ = 1'b0;
        end
    endtask

    task automatic test_reset_mid_shift;
        int guard;
        setup(2'b01, 4'b0001, 4'b0000, 1'b0, 8'd0, 1'b1);
        pulse(4'b0001); tick(4);
        TLU_MODE = 2'b11; tick(1);
        TRIGGER_IN = 4'b0001; tick(2); TRIGGER_IN = 4'b0000;
        guard = 0;
        while (TLU_CLOCK !== 1'b1 && guard < 50) begin tick(1); guard++; end
        tick(20);
        total++;
        if (TLU_BUSY !== 1'b1 || FIFO_EMPTY !== 1'b0) begin
            bad++; $display("FAIL rst_pre: got busy=%b empty=%b want 1/0", TLU_BUSY, FIFO_EMPTY);
        end
        BUS_RST = 1'b1; tick(1);
        total++;
        if ({TLU_CLOCK, TLU_BUSY, FIFO_EMPTY} !== 3'b001 || FIFO_DATA !== 32'h0) begin
            bad++; $display("FAIL rst_mid_shift: got clk/busy/empty=%b data=%h want 001/0", {TLU_CLOCK, TLU_BUSY, FIFO_EMPTY}, FIFO_DATA);
        end
        BUS_RST = 1'b0; TLU_MODE = 2'b01; tick(1);
        pulse(4'b0001); tick(4);
        total++;
        if (FIFO_EMPTY !== 1'b0 || FIFO_DATA !== 32'h8000_0000) begin
            bad++; $display("FAIL rst_next_number: got empty=%b data=%h want 0/80000000", FIFO_EMPTY, FIFO_DATA);
        end
    endtask

    initial begin
        BUS_RST = 1'b1; TRIGGER_IN = '0; ENABLE_MASK = '0; INVERT_MASK = '0; COINCIDENCE_AND = 1'b0;
        TLU_MODE = 2'b00; DATA_MSB_FIRST = 1'b0; LOW_TIMEOUT = 8'd0; COUNTER_RESET = 1'b0;
        CMD_READY = 1'b1; FIFO_NEAR_FULL = 1'b0; FIFO_READ = 1'b0;
        test_reset;
        test_mode01_or;
        test_and_invert;
        test_disabled;
        test_mode11_shift;
        test_timeout;
        test_overflow;
        test_back_to_back;
        test_reset_mid_shift;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
